// File: rtl/pdm_stream_player_if.sv
// ---------------------------------------------------------------------------
// pdm_stream_player_if
//   DelayBuffer Port B read channel used by pdm_stream_player.
//
//   read_address  ADDR_WIDTH  word address presented to the buffer
//   read_en       1           one-cycle read pulse
//   data_in       DATA_WIDTH  read data, valid READ_LATENCY cycles after
//                             the cycle in which read_en was high
//
//   master : the player (drives address/enable, receives data)
//   slave  : the memory  (receives address/enable, drives data)
// ---------------------------------------------------------------------------
interface pdm_stream_player_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] read_address;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] data_in;

  modport master (
    output read_address,
    output read_en,
    input  data_in
  );

  modport slave (
    input  read_address,
    input  read_en,
    output data_in
  );
endinterface

// File: rtl/pdm_stream_player.sv
// ---------------------------------------------------------------------------
// pdm_stream_player
//   Streams signed samples out of the DelayBuffer through a programmable loop
//   window and turns them into a 1-bit PDM stream with a first-order
//   sigma-delta modulator. One sample is fetched and loaded every OSR clocks.
//   When stopped, the modulator keeps running on sample 0, so the output is
//   the alternating 0/1 idle pattern and never glitches.
//
// Ports
//   clk            PDM clock (one sample every OSR cycles)
//   rst_n          asynchronous active-low reset
//   enable         play request (level)
//   loop_start     first address of the loop window
//   loop_end       last address of the loop window (may be below loop_start,
//                  in which case the walk wraps through the top of memory)
//   atten          attenuation select, 0..3 -> 0/-6/-12/-18 dB
//   mem            DelayBuffer Port B (pdm_stream_player_if.master)
//   PDM_out        registered PDM bit
//   sample_strobe  one-cycle pulse aligned with a new sample in the modulator
//   playing        high while in PRIME or RUN
//
// Build option
//   ATTEN_EN  when defined, the modulator input is the stored sample
//             arithmetically shifted right by atten (applied live). When
//             undefined, atten is ignored and no shifter is built.
// ---------------------------------------------------------------------------
module pdm_stream_player #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int OSR          = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] loop_start,
  input  logic [ADDR_WIDTH-1:0] loop_end,
  input  logic [1:0]            atten,
  pdm_stream_player_if.master   mem,
  output logic                  PDM_out,
  output logic                  sample_strobe,
  output logic                  playing
);

  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OSR - 1);
  // Issuing the read here lands valid data on the last cycle of the period.
  localparam logic [CNT_W-1:0] CNT_FETCH = CNT_W'(OSR - 2 - READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_PRIME = CNT_W'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]         addr, addr_nxt;
  logic                          rd_en, rd_en_nxt;
  logic                          strobe, strobe_nxt;
  logic signed [DATA_WIDTH-1:0]  sample_p0, sample_nxt;
  logic signed [DATA_WIDTH-1:0]  mod_in;
  logic [DATA_WIDTH:0]           sum;
  logic [DATA_WIDTH-1:0]         acc_p1;
  logic                          pdm_p1;

  // Loop-window successor; a plain +1 wraps naturally at 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [ADDR_WIDTH-1:0] ls,
    input logic [ADDR_WIDTH-1:0] le
  );
    return (a == le) ? ls : a + 1'b1;
  endfunction

  // Signed two's complement to offset binary: full-scale negative -> 0.
  function automatic logic [DATA_WIDTH-1:0] to_offset(
    input logic signed [DATA_WIDTH-1:0] s
  );
    return {~s[DATA_WIDTH-1], s[DATA_WIDTH-2:0]};
  endfunction

`ifdef ATTEN_EN
  function automatic logic signed [DATA_WIDTH-1:0] attenuate(
    input logic signed [DATA_WIDTH-1:0] s,
    input logic [1:0]                   sh
  );
    return s >>> sh;
  endfunction
`endif

  // Sequencer: next state, counter, read request and sample load.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = addr;
    rd_en_nxt  = 1'b0;
    strobe_nxt = 1'b0;
    sample_nxt = sample_p0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable) begin
          addr_nxt  = loop_start;
          rd_en_nxt = 1'b1;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        // cnt counts cycles since the priming read; enable is not looked
        // at here, so a short request still plays one full period.
        if (cnt == CNT_PRIME) begin
          sample_nxt = $signed(mem.data_in);
          strobe_nxt = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == CNT_FETCH) begin
          addr_nxt  = next_addr(addr, loop_start, loop_end);
          rd_en_nxt = 1'b1;
        end
        if (cnt == CNT_LAST) begin
          if (enable) begin
            sample_nxt = $signed(mem.data_in);
            strobe_nxt = 1'b1;
          end else begin
            // Stop only on a period boundary; the prefetched word is dropped.
            sample_nxt = '0;
            state_nxt  = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: control registers and the stored sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      rd_en     <= 1'b0;
      strobe    <= 1'b0;
      sample_p0 <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr      <= addr_nxt;
      rd_en     <= rd_en_nxt;
      strobe    <= strobe_nxt;
      sample_p0 <= sample_nxt;
    end
  end

`ifdef ATTEN_EN
  always_comb mod_in = attenuate(sample_p0, atten);
`else
  logic unused_atten;
  assign unused_atten = ^atten;
  always_comb mod_in = sample_p0;
`endif

  always_comb sum = {1'b0, acc_p1} + {1'b0, to_offset(mod_in)};

  // Stage p1: sigma-delta accumulator; the carry out is the PDM bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
      pdm_p1 <= 1'b0;
    end else begin
      acc_p1 <= sum[DATA_WIDTH-1:0];
      pdm_p1 <= sum[DATA_WIDTH];
    end
  end

  assign mem.read_address = addr;
  assign mem.read_en      = rd_en;
  assign PDM_out          = pdm_p1;
  assign sample_strobe    = strobe;
  assign playing          = (state != IDLE);

endmodule

// File: tb/tb_pdm_stream_player.sv
// ---------------------------------------------------------------------------
// tb_pdm_stream_player
//   Self-checking bench for pdm_stream_player. A behavioural DelayBuffer with
//   a two-cycle read latency answers reads; expected addresses and read data
//   are queued when a play window is started and checked as the player
//   issues reads and strobes.
// ---------------------------------------------------------------------------
module tb_pdm_stream_player;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int OSR = 32;
  localparam int RL  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] loop_start = '0;
  logic [AW-1:0] loop_end = '0;
  logic [1:0]    atten = 2'd0;
  logic          PDM_out;
  logic          sample_strobe;
  logic          playing;

  int errors = 0;
  int checks = 0;

  int            mem_mode = 0;      // 0: address-dependent words, 1: const_val
  logic [DW-1:0] const_val = '0;
  logic          rd_v1 = 1'b0;
  logic [AW-1:0] rd_a1 = '0;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  pdm_stream_player_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  pdm_stream_player #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .OSR         (OSR),
    .READ_LATENCY(RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .loop_start   (loop_start),
    .loop_end     (loop_end),
    .atten        (atten),
    .mem          (bus),
    .PDM_out      (PDM_out),
    .sample_strobe(sample_strobe),
    .playing      (playing)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, a[7:0]};
  endfunction

  // Two-cycle memory: data is valid only in the cycle READ_LATENCY after the
  // read pulse; any other cycle shows a poison word.
  always @(posedge clk) begin
    rd_v1 <= bus.read_en;
    rd_a1 <= bus.read_address;
    bus.data_in <= rd_v1 ? ((mem_mode != 0) ? const_val : mem_word(rd_a1)) : 16'hDEAD;
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3 * OSR && !ok; c++) begin
      @(negedge clk);
      if (!playing) ok = 1'b1;
    end
  endtask

  task automatic wait_strobe(input int n, output bit ok);
    int seen;
    seen = 0;
    for (int c = 0; c < (n + 1) * OSR + 10 && seen < n; c++) begin
      @(negedge clk);
      if (sample_strobe) seen++;
    end
    ok = (seen == n);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (PDM_out) ones++;
    end
  endtask

  task automatic test_reset();
    logic exp_b;
    int   bad_pdm, bad_ctl;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.read_en, PDM_out, sample_strobe, playing} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000", {bus.read_en, PDM_out, sample_strobe, playing});
    end
    checks++;
    if (bus.read_address !== 16'h0000) begin
      errors++;
      $display("FAIL reset_address got=%h want=0000", bus.read_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad_pdm = 0;
    bad_ctl = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_b = (k % 2 == 0);
      if (PDM_out !== exp_b) bad_pdm++;
      if ({bus.read_en, sample_strobe, playing} !== 3'b000) bad_ctl++;
    end
    checks++;
    if (bad_pdm != 0) begin
      errors++;
      $display("FAIL silence_pattern got=%0d bad cycles want=0", bad_pdm);
    end
    checks++;
    if (bad_ctl != 0) begin
      errors++;
      $display("FAIL idle_control got=%0d bad cycles want=0", bad_ctl);
    end
  endtask

  task automatic test_loop(input logic [AW-1:0] ls, input logic [AW-1:0] le, input int nreads);
    logic [AW-1:0] a;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            last_rd, last_st;
    bit            ok;
    mem_mode   = 0;
    loop_start = ls;
    loop_end   = le;
    a = ls;
    for (int i = 0; i < nreads; i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(mem_word(a));
      a = (a == le) ? ls : a + 16'd1;
    end
    enable  = 1'b1;
    last_rd = -1;
    last_st = -1;
    for (int c = 0; c < nreads * OSR + 20 && (exp_addr.size() > 0 || exp_data.size() > 0); c++) begin
      @(negedge clk);
      if (bus.read_en && exp_addr.size() > 0) begin
        ea = exp_addr.pop_front();
        checks++;
        if (bus.read_address !== ea) begin
          errors++;
          $display("FAIL read_address got=%h want=%h", bus.read_address, ea);
        end
        if (last_rd >= 0) begin
          checks++;
          if (c - last_rd != OSR) begin
            errors++;
            $display("FAIL read_spacing got=%0d want=%0d", c - last_rd, OSR);
          end
        end
        last_rd = c;
      end
      if (sample_strobe && exp_data.size() > 0) begin
        ed = exp_data.pop_front();
        checks++;
        if (dut.sample_p0 !== ed) begin
          errors++;
          $display("FAIL captured_sample got=%h want=%h", dut.sample_p0, ed);
        end
        if (last_st >= 0) begin
          checks++;
          if (c - last_st != OSR) begin
            errors++;
            $display("FAIL strobe_spacing got=%0d want=%0d", c - last_st, OSR);
          end
        end
        last_st = c;
      end
    end
    checks++;
    if (exp_addr.size() + exp_data.size() != 0) begin
      errors++;
      $display("FAIL loop_timeout got=%0d outstanding want=0", exp_addr.size() + exp_data.size());
    end
    exp_addr.delete();
    exp_data.delete();
    enable = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loop_stop got=playing want=idle");
    end
  endtask

  task automatic test_density();
    int ones;
    bit ok;
    mem_mode   = 1;
    const_val  = 16'h7FFF;
    loop_start = 16'h0000;
    loop_end   = 16'h0003;
    enable     = 1'b1;
    wait_strobe(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL density_start got=no strobe want=strobe");
    end
    repeat (2) @(negedge clk);
    count_ones(1024, ones);
    checks++;
    if (ones < 1023) begin
      errors++;
      $display("FAIL density_7fff got=%0d want>=1023", ones);
    end
    const_val = 16'h8000;
    wait_strobe(2, ok);
    repeat (2) @(negedge clk);
    count_ones(1024, ones);
    checks++;
    if (ones != 0) begin
      errors++;
      $display("FAIL density_8000 got=%0d want=0", ones);
    end
    const_val = 16'h4000;
    wait_strobe(2, ok);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      count_ones(64, ones);
      checks++;
      if (ones < 47 || ones > 49) begin
        errors++;
        $display("FAIL density_4000 got=%0d want=47..49", ones);
      end
    end
    enable = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL density_stop got=playing want=idle");
    end
  endtask

`ifdef ATTEN_EN
  task automatic test_atten();
    int ones;
    bit ok;
    mem_mode  = 1;
    const_val = 16'h7FFF;
    atten     = 2'd1;
    enable    = 1'b1;
    wait_strobe(2, ok);
    repeat (2) @(negedge clk);
    count_ones(1024, ones);
    checks++;
    if (ones < 766 || ones > 770) begin
      errors++;
      $display("FAIL atten1 got=%0d want=766..770", ones);
    end
    atten = 2'd3;
    repeat (2) @(negedge clk);
    count_ones(1024, ones);
    checks++;
    if (ones < 574 || ones > 578) begin
      errors++;
      $display("FAIL atten3 got=%0d want=574..578", ones);
    end
    atten  = 2'd0;
    enable = 1'b0;
    wait_idle(ok);
  endtask
`endif

  task automatic test_stop();
    bit   ok;
    int   bad_play, bad_rd, bad_tog;
    logic prev;
    mem_mode   = 0;
    loop_start = 16'h0010;
    loop_end   = 16'h0012;
    enable     = 1'b1;
    wait_strobe(1, ok);         // now in the counter==0 cycle
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stop_start got=no strobe want=strobe");
    end
    repeat (5) @(negedge clk);  // counter==5
    enable   = 1'b0;
    bad_play = 0;
    for (int c = 6; c <= OSR - 1; c++) begin
      @(negedge clk);
      if (!playing || sample_strobe) bad_play++;
    end
    checks++;
    if (bad_play != 0) begin
      errors++;
      $display("FAIL stop_early got=%0d bad cycles want=0", bad_play);
    end
    @(negedge clk);
    checks++;
    if ({playing, sample_strobe} !== 2'b00) begin
      errors++;
      $display("FAIL stop_idle got=%b want=00", {playing, sample_strobe});
    end
    checks++;
    if (dut.sample_p0 !== 16'sd0) begin
      errors++;
      $display("FAIL stop_sample got=%h want=0000", dut.sample_p0);
    end
    @(negedge clk);
    prev    = PDM_out;
    bad_rd  = 0;
    bad_tog = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.read_en) bad_rd++;
      if (PDM_out === prev) bad_tog++;
      prev = PDM_out;
    end
    checks++;
    if (bad_rd != 0) begin
      errors++;
      $display("FAIL stop_reads got=%0d want=0", bad_rd);
    end
    checks++;
    if (bad_tog != 0) begin
      errors++;
      $display("FAIL stop_silence got=%0d bad cycles want=0", bad_tog);
    end
  endtask

  task automatic test_prime_stop();
    int n_play, n_rd, n_st;
    mem_mode   = 0;
    loop_start = 16'h0010;
    loop_end   = 16'h0012;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n_play = playing ? 1 : 0;
    n_rd   = bus.read_en ? 1 : 0;
    n_st   = sample_strobe ? 1 : 0;
    for (int c = 0; c < 3 * OSR; c++) begin
      @(negedge clk);
      if (playing) n_play++;
      if (bus.read_en) n_rd++;
      if (sample_strobe) n_st++;
    end
    checks++;
    if (n_play != RL + 1 + OSR) begin
      errors++;
      $display("FAIL prime_stop_len got=%0d want=%0d", n_play, RL + 1 + OSR);
    end
    checks++;
    if (n_st != 1) begin
      errors++;
      $display("FAIL prime_stop_strobes got=%0d want=1", n_st);
    end
    checks++;
    if (n_rd != 2) begin
      errors++;
      $display("FAIL prime_stop_reads got=%0d want=2", n_rd);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    mem_mode   = 0;
    loop_start = 16'h0010;
    loop_end   = 16'h0012;
    enable     = 1'b1;
    wait_strobe(2, ok);
    repeat (10) @(negedge clk);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if ({bus.read_en, PDM_out, sample_strobe, playing} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_outputs got=%b want=0000", {bus.read_en, PDM_out, sample_strobe, playing});
    end
    checks++;
    if (bus.read_address !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_address got=%h want=0000", bus.read_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (PDM_out !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_pdm0 got=%b want=0", PDM_out);
    end
    @(negedge clk);
    checks++;
    if (PDM_out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pdm1 got=%b want=1", PDM_out);
    end
  endtask

  initial begin
    test_reset();
    test_loop(16'h0010, 16'h0012, 7);
    test_loop(16'hFFFE, 16'h0001, 6);
    test_density();
`ifdef ATTEN_EN
    test_atten();
`endif
    test_stop();
    test_prime_stop();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdm_stream_player.md
Name: pdm_stream_player

Overview:
- Parametrised successor to the single-channel bit-serial audio output.
- Sequences reads from the DelayBuffer Port B through a programmable loop window, with a configurable memory read latency.
- Converts each signed sample to a 1-bit stream with a first-order sigma-delta modulator, to drive the Nexys4DDR audio jack.
- Adds play/stop control with a glitch-free idle stream.

Parameters:
- DATA_WIDTH, 16: sample width in bits, signed two's complement.
- ADDR_WIDTH, 16: DelayBuffer address width.
- OSR, 32: clk cycles per sample (oversampling ratio). Must satisfy OSR >= READ_LATENCY+2.
- READ_LATENCY, 2: cycles from a read_en-high cycle until data_in is valid.

Ports:
- clk  in  1  single clock for the block (1.5 MHz PDM clock).
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- enable  in  1  play request, level-sensitive.
- loop_start  in  ADDR_WIDTH  first address of the loop window.
- loop_end  in  ADDR_WIDTH  last address of the loop window.
- atten  in  2  attenuation select; used only with ATTEN_EN.
- data_in  in  DATA_WIDTH  DelayBuffer Port B read data.
- read_address  out  ADDR_WIDTH  DelayBuffer Port B address.
- read_en  out  1  DelayBuffer Port B enable; one-cycle pulse per read.
- PDM_out  out  1  registered PDM bit to the audio jack.
- sample_strobe  out  1  one-cycle pulse when a new sample is loaded into the modulator.
- playing  out  1  high in the PRIME and RUN states.

Behaviour:
- Reset values (asynchronous, rst_n=0): read_address=0, read_en=0, PDM_out=0, sample_strobe=0, playing=0, state=IDLE, counter=0, sample register=0, accumulator=0.
- FSM states are IDLE, PRIME and RUN.
- IDLE:
  - The modulator runs on sample value 0, producing the alternating 0/1 silence pattern.
  - On enable=1: read_address<=loop_start, read_en<=1, go to PRIME.
- PRIME:
  - Wait READ_LATENCY cycles after the read_en cycle.
  - Then capture data_in into the sample register, pulse sample_strobe, set counter=0 and enter RUN.
- RUN:
  - The counter runs 0..OSR-1 and wraps.
  - At counter==OSR-2-READ_LATENCY: read_address<=next(read_address), read_en<=1 for one cycle.
  - At counter==OSR-1: sample register<=data_in, sample_strobe=1.
  - Exactly one read and one strobe occur per OSR cycles.
- next(a): if a==loop_end then loop_start, else a+1 modulo 2^ADDR_WIDTH.
  - If loop_end<loop_start, the address walks through the natural wrap until it reaches loop_end.
  - loop_start and loop_end are sampled at the time of use; changing them mid-run takes effect at the next address computation.
- Stop: enable=0 in RUN is honoured only at counter==OSR-1.
  - No reload happens; the sample register is cleared to 0 and the FSM goes to IDLE. The current sample always completes.
  - No read is issued after stop is taken. A read already prefetched in that period is discarded.
- enable=0 during PRIME: finish PRIME, play one full sample period, then stop per the rule above.
- Modulator, every cycle in all states:
  - u = sample with MSB inverted (offset binary, DATA_WIDTH bits).
  - sum = acc + u, where acc is DATA_WIDTH bits and sum is DATA_WIDTH+1 bits.
  - PDM_out<=sum[DATA_WIDTH] (the carry); acc<=sum[DATA_WIDTH-1:0].
  - PDM_out therefore lags the accumulate by 1 register stage.
  - The accumulator is never reset except by rst_n.
- Asserting rst_n mid-operation aborts immediately to reset values. There is no pending read state.

Optional Feature:
- ATTEN_EN defined: the sample feeding the modulator is the stored sample arithmetically right-shifted (sign-preserving) by atten, 0..3 (0/-6/-12/-18 dB). atten is applied live each cycle.
- ATTEN_EN undefined: atten is ignored and no shifter is synthesized; the modulator sees the stored sample directly.

Test Plan:
- Reset, enable=0, DATA_WIDTH=16: PDM_out reads 0,1,0,1,... after the first post-reset cycle. read_en never pulses. playing=0.
- enable=1, loop_start=0x0010, loop_end=0x0012, memory returns addr-dependent data with latency 2: read_address sequence 0x10,0x11,0x12,0x10,...; read_en exactly once per 32 cycles; sample_strobe exactly 32 cycles apart; captured data matches the address issued READ_LATENCY cycles earlier.
- All samples 0x7FFF: over 1024 cycles PDM_out ones count >= 1023. All samples 0x8000: PDM_out is all 0. Sample 0x4000: ones density is 75% ±1 bit per 64 cycles.
- loop_start=0xFFFE, loop_end=0x0001: read_address sequence 0xFFFE,0xFFFF,0x0000,0x0001,0xFFFE.
- Deassert enable at counter=5 in RUN: the current sample plays until counter==31, then IDLE. No further read_en. playing falls the cycle after counter==31. The silence pattern resumes.
- ATTEN_EN defined, sample 0x7FFF, atten=1: density ~75% (offset of 0x3FFF). atten=3: density ~56%. Pulse rst_n low mid-RUN: all outputs go to reset values asynchronously.
